// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire sensor reader.
// Imported by dht11_reader; the checksum helper is used only when DHT11_CHECKSUM_EN is defined.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_RESP,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK
    } state_t;

    localparam int RESP_TIMEOUT_US  = 100;
    localparam int BIT_THRESHOLD_US = 40;
    localparam int FRAME_BITS       = 40;

    // 8-bit wrap-around sum of the four data bytes (bits 39..8 of a frame).
    function automatic logic [7:0] frame_sum(input logic [39:0] frame);
        return frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    endfunction

endpackage

// File: rtl/dht11_tick_gen.sv
// Free-running 1 us and 1 ms strobes derived from the system clock.
// Both strobes are single-cycle and phase-aligned (ms strobe coincides with a us strobe).
module dht11_tick_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic us_tick_o,
    output logic ms_tick_o
);

    localparam int DIV   = CLK_FREQ_HZ / 1_000_000;
    localparam int DIV_W = $clog2(DIV + 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       ms_cnt_q, ms_cnt_d;

    always_comb begin
        us_tick_o = (div_q == DIV_W'(DIV - 1));
        ms_tick_o = us_tick_o && (ms_cnt_q == 10'd999);
        div_d     = us_tick_o ? '0 : div_q + 1'b1;
        ms_cnt_d  = ms_cnt_q;
        if (us_tick_o) begin
            ms_cnt_d = ms_tick_o ? '0 : ms_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q    <= '0;
            ms_cnt_q <= '0;
        end else begin
            div_q    <= div_d;
            ms_cnt_q <= ms_cnt_d;
        end
    end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 reader: periodic start pulse, edge-timed 40-bit capture, held outputs with fail-tolerant valid.
// Define DHT11_CHECKSUM_EN to reject frames whose byte4 does not match the data-byte sum.
module dht11_reader
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int SAMPLE_PERIOD_MS = 2000,
    parameter int START_LOW_MS     = 20,
    parameter int FAIL_LIMIT       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_in,
    output logic       dht_drive_low,
    output logic [7:0] humidity_int,
    output logic [7:0] humidity_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec,
    output logic       humidity_valid,
    output logic       data_update,
    output logic       frame_err,
    output state_t     dbg_state
);

    localparam logic [15:0] PERIOD_LAST = 16'(SAMPLE_PERIOD_MS - 1);
    localparam logic [15:0] START_LAST  = 16'(START_LOW_MS - 1);
    localparam logic [7:0]  FAIL_MAX    = 8'(FAIL_LIMIT);

    logic        us_tick, ms_tick;
    logic [1:0]  sync_q;
    logic        line_prev_q;
    logic        fall, rise;
    state_t      state_q, state_d;
    logic [15:0] period_q, period_d;
    logic [7:0]  us_cnt_q, us_cnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [39:0] shreg_q, shreg_d;
    logic [8:0]  width_now;
    logic        wait_state, timeout, abort, bit_val, frame_good, fail_hit;
    logic [7:0]  hum_int_q, hum_dec_q, temp_int_q, temp_dec_q, fail_q;
    logic        valid_q, update_q, err_q, drive_q;

    dht11_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk_i    (clk),
        .rst_i    (rst),
        .us_tick_o(us_tick),
        .ms_tick_o(ms_tick)
    );

    // The idle line is pulled up, so the synchronizer resets high to avoid a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[0], dht_in};
            line_prev_q <= sync_q[1];
        end
    end

    assign fall = line_prev_q & ~sync_q[1];
    assign rise = ~line_prev_q & sync_q[1];

    // Width in state including the tick consumed on this cycle.
    assign width_now  = {1'b0, us_cnt_q} + {8'd0, us_tick};
    assign timeout    = width_now >= 9'(RESP_TIMEOUT_US);
    assign bit_val    = width_now > 9'(BIT_THRESHOLD_US);
    assign wait_state = state_q inside {ST_WAIT_RESP, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH};

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        abort     = 1'b0;
        if (ms_tick && period_q != PERIOD_LAST) begin
            period_d = period_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (ms_tick && period_q == PERIOD_LAST) begin
                    state_d   = ST_START;
                    period_d  = '0;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            // The period counter doubles as the start-pulse timer since it restarts on START entry.
            ST_START:     if (ms_tick && period_q == START_LAST) state_d = ST_WAIT_RESP;
            ST_WAIT_RESP: if (fall) state_d = ST_RESP_LOW;
            ST_RESP_LOW:  if (rise) state_d = ST_RESP_HIGH;
            ST_RESP_HIGH: if (fall) state_d = ST_BIT_LOW;
            ST_BIT_LOW:   if (rise) state_d = ST_BIT_HIGH;
            ST_BIT_HIGH: begin
                if (fall) begin
                    shreg_d   = {shreg_q[38:0], bit_val};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? ST_CHECK : ST_BIT_LOW;
                end
            end
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (wait_state && timeout) begin
            abort     = 1'b1;
            state_d   = ST_IDLE;
            shreg_d   = '0;
            bit_cnt_d = '0;
        end
        us_cnt_d = us_cnt_q;
        if (state_d != state_q) begin
            us_cnt_d = '0;
        end else if (us_tick && us_cnt_q != 8'hFF) begin
            us_cnt_d = us_cnt_q + 1'b1;
        end
    end

    always_comb begin
`ifdef DHT11_CHECKSUM_EN
        frame_good = (frame_sum(shreg_q) == shreg_q[7:0]);
`else
        frame_good = 1'b1;
`endif
        fail_hit = abort | ((state_q == ST_CHECK) & ~frame_good);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            period_q  <= '0;
            us_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            us_cnt_q  <= us_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drive_q    <= 1'b0;
            hum_int_q  <= '0;
            hum_dec_q  <= '0;
            temp_int_q <= '0;
            temp_dec_q <= '0;
            valid_q    <= 1'b0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
            fail_q     <= '0;
        end else begin
            drive_q  <= (state_d == ST_START);
            update_q <= 1'b0;
            err_q    <= fail_hit;
            if (state_q == ST_CHECK && frame_good) begin
                hum_int_q  <= shreg_q[39:32];
                hum_dec_q  <= shreg_q[31:24];
                temp_int_q <= shreg_q[23:16];
                temp_dec_q <= shreg_q[15:8];
                update_q   <= 1'b1;
                valid_q    <= 1'b1;
                fail_q     <= '0;
            end else if (fail_hit) begin
                if (fail_q != FAIL_MAX) fail_q <= fail_q + 1'b1;
                if (fail_q + 8'd1 >= FAIL_MAX) valid_q <= 1'b0;
            end
        end
    end

    assign dht_drive_low  = drive_q;
    assign humidity_int   = hum_int_q;
    assign humidity_dec   = hum_dec_q;
    assign temp_int       = temp_int_q;
    assign temp_dec       = temp_dec_q;
    assign humidity_valid = valid_q;
    assign data_update    = update_q;
    assign frame_err      = err_q;
    assign dbg_state      = state_q;

endmodule

// File: doc/dht11_reader.md
# dht11_reader

Single-wire DHT11 humidity/temperature sensor reader that feeds the alarm controller's `humidity_int`/`humidity_valid` inputs. It periodically issues the host start pulse and times the sensor's response and 40 data bits against a microsecond tick. It then checks the frame and publishes held, registered readings with a validity flag that tolerates occasional bad frames.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: system clock frequency; must be an integer multiple of 1_000_000.
- `SAMPLE_PERIOD_MS`, 2000: time from one transaction start to the next.
- `START_LOW_MS`, 20: host start-pulse length.
- `FAIL_LIMIT`, 3: consecutive failed frames that clear `humidity_valid`.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `dht_in` input 1: raw sensor line level (asynchronous).
- `dht_drive_low` output 1: 1 means the pad drives the line low; 0 means released (pull-up).
- `humidity_int` output 8: humidity, integer part (%RH).
- `humidity_dec` output 8: humidity, decimal byte.
- `temp_int` output 8: temperature, integer part (°C).
- `temp_dec` output 8: temperature, decimal byte.
- `humidity_valid` output 1: at least one good frame and fewer than `FAIL_LIMIT` consecutive failures since then.
- `data_update` output 1: one-cycle pulse when the data registers load.
- `frame_err` output 1: one-cycle pulse on timeout or checksum failure.

## Operation
- `dht_in` passes through a 2-FF synchronizer; edges are detected on the synchronized level.
- Tick generator produces a 1 µs tick (every `CLK_FREQ_HZ/1e6` clocks) and a 1 ms tick (every 1000 µs ticks).
- FSM states:
  - IDLE: count ms ticks; at `SAMPLE_PERIOD_MS`, go to START.
  - START: `dht_drive_low`=1 for `START_LOW_MS` ms, then release and go to WAIT_RESP.
  - WAIT_RESP: wait for a falling edge, then go to RESP_LOW.
  - RESP_LOW: wait for a rising edge, then go to RESP_HIGH.
  - RESP_HIGH: wait for a falling edge, then go to BIT_LOW.
  - BIT_LOW: wait for a rising edge, then go to BIT_HIGH.
  - BIT_HIGH: on a falling edge, shift in 1 if the high width is >40 µs, else 0. After 40 bits go to CHECK; otherwise go to BIT_LOW.
  - CHECK: validate the frame, then go to IDLE.
- In every wait state, a µs counter clears on state entry and saturates at 255. Reaching 100 µs causes a timeout: `frame_err` pulses, the shift register is discarded, and the FSM goes to IDLE.
- Frame format is MSB first: byte0 humidity_int, byte1 humidity_dec, byte2 temp_int, byte3 temp_dec, byte4 checksum.
- Checksum rule: the 8-bit sum of bytes 0–3 modulo 256 must equal byte4.
- Good frame: all four data outputs load, `data_update` pulses, `humidity_valid`=1, and the fail counter clears.
- Bad frame: the fail counter increments, saturating at `FAIL_LIMIT`. Upon reaching `FAIL_LIMIT`, `humidity_valid`=0. Data outputs hold their last good values.
- The period counter runs from START entry, independent of how the transaction ends.

## Timing
- Reset values: `dht_drive_low`=0, all data outputs 0, `humidity_valid`=0, `data_update`=0, `frame_err`=0, FSM in IDLE, all counters 0.
- Reset asserted mid-transaction: the line releases asynchronously. The first start pulse after reset release begins `SAMPLE_PERIOD_MS` after release; this doubles as the sensor power-up settle time.
- Latency: a pad edge is seen by the FSM 2 clocks later. Outputs and `data_update`/`frame_err` register 1 clock after the FSM event (the 40th falling edge or the timeout).
- `dht_drive_low` is registered. Its high time is exactly `START_LOW_MS`×1000 µs ticks.
- Bit-width boundaries: exactly 40 µs decodes as 0; 41 µs decodes as 1. A timeout occurs at the 100th µs tick in state.

## Configuration
- `DHT11_CHECKSUM_EN` defined: a checksum mismatch counts as a bad frame (`frame_err` pulses, no update).
- `DHT11_CHECKSUM_EN` undefined: byte4 is ignored; every complete 40-bit frame is good. Timeouts still count as failures.

## Structure
- Package `dht11_pkg`:
  - FSM state enum.
  - Constants: `RESP_TIMEOUT_US`=100, `BIT_THRESHOLD_US`=40, `FRAME_BITS`=40.
- Sub-module `dht11_tick_gen`: generates the µs and ms ticks from `CLK_FREQ_HZ`.
- The FSM, shift register, and output registers stay in the top-level module.

## Test plan
Bench settings: `CLK_FREQ_HZ`=1_000_000, `SAMPLE_PERIOD_MS`=5, `START_LOW_MS`=1, behavioural sensor model.
- Start pulse: `dht_drive_low` is high for exactly 1000 clocks, beginning 5000 clocks after reset release, and repeats every 5000 clocks.
- Good frame 0x41,0x00,0x19,0x00,0x5A: `humidity_int`=65, `temp_int`=25, `humidity_valid`=1, and `data_update` pulses once.
- Frame 0x41,0x00,0x19,0x00,0x5B:
  - With the macro: `frame_err` pulses and outputs hold.
  - Without the macro: `humidity_int`=65 and `data_update` pulses.
- Sensor silent (line high):
  - `frame_err` pulses 100 µs after release.
  - After the 3rd consecutive failure, `humidity_valid`=0 while `humidity_int` holds its last value.
- Bit high widths of 40/41 µs decode as 0/1. A 100 µs high mid-frame causes a timeout, and the next good frame recovers `humidity_valid`=1.
- `rst` asserted during BIT_HIGH: `dht_drive_low`=0 and all outputs are 0 immediately, and no `data_update` follows.
